// File: rtl/housekeeping_spi_sync.sv
// Housekeeping SPI slave: SCK/CSB/SDI are oversampled in the system clock domain and decoded into
// register-file write strobes and a req/ack read port, with flash pass-through mode flags.
module housekeeping_spi_sync #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int SYNC_FF = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              spi_sck_i,
  input  logic              spi_csb_i,
  input  logic              spi_sdi_i,
  output logic              spi_sdo_o,
  output logic              spi_sdoenb_o,
  output logic              wr_stb_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_ack_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              pass_thru_mgmt_o,
  output logic              pass_thru_user_o,
  output logic              busy_o,
  output logic              err_underrun_o
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_PASS_M, S_PASS_U} state_t;

  localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic [SYNC_FF-1:0] r_sck_sync;
  logic [SYNC_FF-1:0] r_csb_sync;
  logic [SYNC_FF-1:0] r_sdi_sync;
  logic               r_sck_d;
  logic               r_csb_d;

  logic               w_sck, w_csb, w_sdi;
  logic               w_sck_rise, w_sck_fall, w_csb_rise, w_csb_fall, w_ack;
  logic [ADDR_W-1:0]  w_addr_rx, w_addr_inc;
  logic [DATA_W-1:0]  w_word_rx;

  state_t             r_state;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [SH_W-2:0]    r_shift;
  logic               r_cmd_wr, r_cmd_rd, r_stream;
  logic [2:0]         r_words_left;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_sdo_sh;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_valid;

  assign w_sck      = r_sck_sync[SYNC_FF-1];
  assign w_csb      = r_csb_sync[SYNC_FF-1];
  assign w_sdi      = r_sdi_sync[SYNC_FF-1];
  assign w_sck_rise = w_sck & ~r_sck_d & ~w_csb;
  assign w_sck_fall = ~w_sck & r_sck_d & ~w_csb;
  assign w_csb_rise = w_csb & ~r_csb_d;
  assign w_csb_fall = ~w_csb & r_csb_d;
  assign w_addr_rx  = {r_shift[ADDR_W-2:0], w_sdi};
  assign w_word_rx  = {r_shift[DATA_W-2:0], w_sdi};
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_ack      = rd_req_o & rd_ack_i;
  assign spi_sdo_o  = r_sdo_sh[DATA_W-1];
  assign busy_o     = ~w_csb;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_sck_sync       <= '0;
      r_csb_sync       <= '1;
      r_sdi_sync       <= '0;
      r_sck_d          <= 1'b0;
      r_csb_d          <= 1'b1;
      r_state          <= S_IDLE;
      r_bitcnt         <= '0;
      r_shift          <= '0;
      r_cmd_wr         <= 1'b0;
      r_cmd_rd         <= 1'b0;
      r_stream         <= 1'b0;
      r_words_left     <= '0;
      r_addr           <= '0;
      r_sdo_sh         <= '0;
      r_rd_data        <= '0;
      r_rd_valid       <= 1'b0;
      spi_sdoenb_o     <= 1'b1;
      wr_stb_o         <= 1'b0;
      wr_addr_o        <= '0;
      wr_data_o        <= '0;
      rd_req_o         <= 1'b0;
      rd_addr_o        <= '0;
      pass_thru_mgmt_o <= 1'b0;
      pass_thru_user_o <= 1'b0;
      err_underrun_o   <= 1'b0;
    end else begin
      r_sck_sync     <= {r_sck_sync[SYNC_FF-2:0], spi_sck_i};
      r_csb_sync     <= {r_csb_sync[SYNC_FF-2:0], spi_csb_i};
      r_sdi_sync     <= {r_sdi_sync[SYNC_FF-2:0], spi_sdi_i};
      r_sck_d        <= w_sck;
      r_csb_d        <= w_csb;
      wr_stb_o       <= 1'b0;
      err_underrun_o <= 1'b0;

      if (w_ack) begin
        r_rd_data  <= rd_data_i;
        r_rd_valid <= 1'b1;
        rd_req_o   <= 1'b0;
      end

      // CSB release aborts everything, including a pending read and a partial word.
      if (w_csb_rise) begin
        r_state          <= S_IDLE;
        r_bitcnt         <= '0;
        r_cmd_wr         <= 1'b0;
        r_cmd_rd         <= 1'b0;
        r_stream         <= 1'b0;
        r_words_left     <= '0;
        r_sdo_sh         <= '0;
        r_rd_valid       <= 1'b0;
        rd_req_o         <= 1'b0;
        spi_sdoenb_o     <= 1'b1;
        pass_thru_mgmt_o <= 1'b0;
        pass_thru_user_o <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_csb_fall) begin
              r_state  <= S_CMD;
              r_bitcnt <= '0;
            end
          end
          S_CMD: begin
            if (w_sck_rise) begin
              r_shift <= {r_shift[SH_W-3:0], w_sdi};
              if (r_bitcnt == CMD_LAST) begin
                r_bitcnt     <= '0;
                r_cmd_wr     <= r_shift[6];
                r_cmd_rd     <= r_shift[5];
                r_words_left <= r_shift[4:2];
                r_stream     <= (r_shift[4:2] == 3'd0);
                if (r_shift[1]) begin
                  r_state          <= S_PASS_M;
                  pass_thru_mgmt_o <= 1'b1;
                  spi_sdoenb_o     <= 1'b0;
                end else if (r_shift[0]) begin
                  r_state          <= S_PASS_U;
                  pass_thru_user_o <= 1'b1;
                  spi_sdoenb_o     <= 1'b0;
                end else begin
                  r_state <= S_ADDR;
                end
              end else begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
              end
            end
          end
          S_ADDR: begin
            if (w_sck_rise) begin
              r_shift <= {r_shift[SH_W-3:0], w_sdi};
              if (r_bitcnt == ADDR_LAST) begin
                r_bitcnt <= '0;
                r_addr   <= w_addr_rx;
                r_state  <= S_DATA;
                if (r_cmd_rd) begin
                  rd_req_o  <= 1'b1;
                  rd_addr_o <= w_addr_rx;
                end
              end else begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
              end
            end
          end
          S_DATA: begin
            // First fall of a word loads SDO; a still-pending request means the data came too late.
            if (w_sck_fall) begin
              if (r_bitcnt == '0) begin
                r_rd_valid <= 1'b0;
                if (r_cmd_rd) spi_sdoenb_o <= 1'b0;
                if (r_rd_valid) begin
                  r_sdo_sh <= r_rd_data;
                end else if (w_ack) begin
                  r_sdo_sh <= rd_data_i;
                end else begin
                  r_sdo_sh <= '0;
                  if (rd_req_o) begin
                    err_underrun_o <= 1'b1;
                    rd_req_o       <= 1'b0;
                  end
                end
              end else begin
                r_sdo_sh <= {r_sdo_sh[DATA_W-2:0], 1'b0};
              end
            end
            if (w_sck_rise) begin
              r_shift <= {r_shift[SH_W-3:0], w_sdi};
              if (r_bitcnt == DATA_LAST) begin
                r_bitcnt <= '0;
                r_addr   <= w_addr_inc;
                if (r_cmd_wr) begin
                  wr_stb_o  <= 1'b1;
                  wr_addr_o <= r_addr;
                  wr_data_o <= w_word_rx;
                end
                if (!r_stream && r_words_left == 3'd1) begin
                  r_state <= S_CMD;
                end else begin
                  if (!r_stream) r_words_left <= r_words_left - 3'd1;
                  if (r_cmd_rd) begin
                    rd_req_o  <= 1'b1;
                    rd_addr_o <= w_addr_inc;
                  end
                end
              end else begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
              end
            end
          end
          S_PASS_M, S_PASS_U: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_housekeeping_spi_sync.sv
// Directed bench for housekeeping_spi_sync: an 8/8 instance and a 16/32 instance on shared SPI pins,
// each with its own read responder acking two cycles after a request.
module tb_housekeeping_spi_sync;
  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sck, csb, sdi;
  logic ack_en, sel_b;
  logic a_ack, b_ack;
  logic [7:0]  a_rdata;
  logic [31:0] b_rdata;

  logic a_sdo, a_oeb, a_stb, a_rdreq, a_pm, a_pu, a_busy, a_unr;
  logic [7:0] a_wa, a_wd, a_ra;
  logic b_sdo, b_oeb, b_stb, b_rdreq, b_pm, b_pu, b_busy, b_unr;
  logic [15:0] b_wa, b_ra;
  logic [31:0] b_wd;

  housekeeping_spi_sync u_a (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .spi_sck_i(sck), .spi_csb_i(csb), .spi_sdi_i(sdi),
    .spi_sdo_o(a_sdo), .spi_sdoenb_o(a_oeb), .wr_stb_o(a_stb), .wr_addr_o(a_wa), .wr_data_o(a_wd),
    .rd_req_o(a_rdreq), .rd_addr_o(a_ra), .rd_ack_i(a_ack), .rd_data_i(a_rdata),
    .pass_thru_mgmt_o(a_pm), .pass_thru_user_o(a_pu), .busy_o(a_busy), .err_underrun_o(a_unr)
  );

  housekeeping_spi_sync #(.ADDR_W(16), .DATA_W(32), .SYNC_FF(2)) u_b (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .spi_sck_i(sck), .spi_csb_i(csb), .spi_sdi_i(sdi),
    .spi_sdo_o(b_sdo), .spi_sdoenb_o(b_oeb), .wr_stb_o(b_stb), .wr_addr_o(b_wa), .wr_data_o(b_wd),
    .rd_req_o(b_rdreq), .rd_addr_o(b_ra), .rd_ack_i(b_ack), .rd_data_i(b_rdata),
    .pass_thru_mgmt_o(b_pm), .pass_thru_user_o(b_pu), .busy_o(b_busy), .err_underrun_o(b_unr)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] a_wq[$];
  logic [47:0] b_wq[$];
  int a_unr_cnt, b_unr_cnt;
  bit a_oe_seen, b_oe_seen;
  logic [63:0] miso;
  logic [7:0]  a_ack_addr;
  logic [15:0] b_ack_addr;

  typedef struct {
    string      name;
    logic [7:0] cmd, addr, data, rdv;
    bit         exp_stb;
    logic [7:0] exp_wa, exp_wd, exp_miso;
    bit         exp_oe;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (a_stb) a_wq.push_back({a_wa, a_wd});
    if (b_stb) b_wq.push_back({b_wa, b_wd});
    if (a_unr) a_unr_cnt++;
    if (b_unr) b_unr_cnt++;
    if (!a_oeb) a_oe_seen = 1'b1;
    if (!b_oeb) b_oe_seen = 1'b1;
  end

  // Read responders: ack two cycles after the request appears.
  initial begin
    int cnt;
    a_ack = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (a_ack) a_ack = 1'b0;
      else if (a_rdreq && ack_en) begin
        cnt++;
        if (cnt == 2) begin a_ack = 1'b1; a_ack_addr = a_ra; cnt = 0; end
      end else cnt = 0;
    end
  end

  initial begin
    int cnt;
    b_ack = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (b_ack) b_ack = 1'b0;
      else if (b_rdreq && ack_en) begin
        cnt++;
        if (cnt == 2) begin b_ack = 1'b1; b_ack_addr = b_ra; cnt = 0; end
      end else cnt = 0;
    end
  end

  task automatic clear_mon();
    a_wq.delete(); b_wq.delete();
    a_unr_cnt = 0; b_unr_cnt = 0;
    a_oe_seen = 1'b0; b_oe_seen = 1'b0;
    miso = '0;
  endtask

  task automatic csb_low();
    csb = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic csb_high();
    repeat (H) @(negedge clk);
    csb = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      repeat (H) @(negedge clk);
      miso = {miso[62:0], (sel_b ? b_sdo : a_sdo)};
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; sck = 1'b0; csb = 1'b1; sdi = 1'b0; ack_en = 1'b1; sel_b = 1'b0;
    a_rdata = '0; b_rdata = '0; a_ack_addr = '0; b_ack_addr = '0;
    clear_mon();

    vecs[0] = '{"T1 write",      8'h88, 8'h10, 8'hA5, 8'h00, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{"cmd 00",        8'h00, 8'h10, 8'h77, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{"T3 read",       8'h48, 8'h20, 8'h00, 8'h5A, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b1};
    vecs[3] = '{"read+write",    8'hC8, 8'h40, 8'h3C, 8'h99, 1'b1, 8'h40, 8'h3C, 8'h99, 1'b1};
    vecs[4] = '{"stream wr FF",  8'h80, 8'hFF, 8'h01, 8'h00, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_a_bits", {a_sdo, a_oeb, a_stb, a_rdreq, a_pm, a_pu, a_busy, a_unr}, 64'h40);
    chk("reset_a_buses", {a_wa, a_wd, a_ra}, 64'h0);
    chk("reset_b_bits", {b_sdo, b_oeb, b_stb, b_rdreq, b_pm, b_pu, b_busy, b_unr}, 64'h40);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      a_rdata = vecs[i].rdv;
      clear_mon();
      csb_low();
      spi_bits({40'd0, vecs[i].cmd, vecs[i].addr, vecs[i].data}, 24);
      csb_high();
      chk({vecs[i].name, " stb_count"}, a_wq.size(), {63'd0, vecs[i].exp_stb});
      if (vecs[i].exp_stb && a_wq.size() != 0)
        chk({vecs[i].name, " wr_addr_data"}, a_wq[0], {vecs[i].exp_wa, vecs[i].exp_wd});
      chk({vecs[i].name, " sdo_word"}, miso[7:0], vecs[i].exp_miso);
      chk({vecs[i].name, " sdo_enabled"}, a_oe_seen, vecs[i].exp_oe);
      chk({vecs[i].name, " underrun"}, a_unr_cnt, 0);
      chk({vecs[i].name, " idle_after"}, {a_busy, a_oeb, a_rdreq}, 3'b010);
      $display("txn %s: cmd=%h addr=%h strobes=%0d sdo=%h", vecs[i].name, vecs[i].cmd,
               vecs[i].addr, a_wq.size(), miso[7:0]);
    end

    // Counted burst returns to CMD: a second command in the same CSB cycle is honoured.
    clear_mon();
    csb_low();
    spi_bits({16'd0, 48'h88_10_A5_88_11_22}, 48);
    csb_high();
    chk("T1 back_to_cmd count", a_wq.size(), 2);
    if (a_wq.size() == 2) chk("T1 back_to_cmd second", a_wq[1], 16'h1122);
    $display("txn T1 two commands: strobes=%0d", a_wq.size());

    // Streaming write wraps the address.
    clear_mon();
    csb_low();
    spi_bits({24'd0, 40'h80_FE_11_22_33}, 40);
    csb_high();
    chk("T2 count", a_wq.size(), 3);
    if (a_wq.size() == 3) begin
      chk("T2 word0", a_wq[0], 16'hFE11);
      chk("T2 word1", a_wq[1], 16'hFF22);
      chk("T2 word2 wrap", a_wq[2], 16'h0033);
    end
    $display("txn T2 stream wrap: strobes=%0d", a_wq.size());

    // Read never acked: zeros shifted, one underrun pulse, request withdrawn.
    ack_en = 1'b0;
    a_rdata = 8'hFF;
    clear_mon();
    csb_low();
    spi_bits({40'd0, 24'h48_20_FF}, 24);
    chk("T4 req_withdrawn", a_rdreq, 1'b0);
    csb_high();
    chk("T4 sdo_zero", miso[7:0], 8'h00);
    chk("T4 underrun_pulses", a_unr_cnt, 1);
    $display("txn T4 underrun: pulses=%0d sdo=%h", a_unr_cnt, miso[7:0]);

    ack_en = 1'b1;
    a_rdata = 8'hC3;
    clear_mon();
    csb_low();
    spi_bits({40'd0, 24'h48_21_00}, 24);
    csb_high();
    chk("T4 recovery sdo", miso[7:0], 8'hC3);
    chk("T4 recovery addr", a_ack_addr, 8'h21);
    chk("T4 recovery underrun", a_unr_cnt, 0);
    $display("txn T4 recovery: sdo=%h", miso[7:0]);

    // CSB raised mid-word.
    clear_mon();
    csb_low();
    spi_bits({43'd0, 8'h88, 8'h10, 5'b10101}, 21);
    csb_high();
    chk("T5 no_strobe", a_wq.size(), 0);
    chk("T5 idle_outputs", {a_busy, a_oeb, a_sdo, a_rdreq, a_pm, a_pu}, 6'b010000);
    $display("txn T5 abort write: strobes=%0d", a_wq.size());

    // CSB raised with a read request pending: request dropped, late ack ignored.
    ack_en = 1'b0;
    clear_mon();
    csb_low();
    spi_bits({48'd0, 16'h48_30}, 16);
    repeat (2) @(negedge clk);
    chk("T5 read_pending", a_rdreq, 1'b1);
    csb_high();
    chk("T5 read_dropped", a_rdreq, 1'b0);
    ack_en = 1'b1;
    $display("txn T5 abort read");

    // Pass-through modes.
    csb_low();
    spi_bits({56'd0, 8'hC4}, 8);
    repeat (6) @(negedge clk);
    chk("T6 C4 flags", {a_pm, a_pu, a_oeb}, 3'b100);
    spi_bits({56'd0, 8'hFF}, 8);
    chk("T6 C4 held", {a_pm, a_pu, a_oeb}, 3'b100);
    csb_high();
    chk("T6 C4 released", {a_pm, a_pu, a_oeb}, 3'b001);
    $display("txn T6 cmd C4");

    csb_low();
    spi_bits({56'd0, 8'hC6}, 8);
    repeat (6) @(negedge clk);
    chk("T6 C6 mgmt_priority", {a_pm, a_pu, a_oeb}, 3'b100);
    csb_high();
    $display("txn T6 cmd C6");

    csb_low();
    spi_bits({56'd0, 8'h42}, 8);
    repeat (6) @(negedge clk);
    chk("T6 42 user", {a_pm, a_pu, a_oeb}, 3'b010);
    csb_high();
    $display("txn T6 cmd 42");

    // Asynchronous reset during pass-through clears outputs without a clock edge.
    csb_low();
    spi_bits({56'd0, 8'hC4}, 8);
    repeat (6) @(negedge clk);
    chk("reset_mid pre", a_pm, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid outputs", {a_pm, a_pu, a_oeb, a_busy}, 4'b0010);
    csb = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("txn async reset mid-transfer");

    // 16-bit address / 32-bit data instance.
    sel_b = 1'b1;
    b_rdata = 32'hCAFEF00D;
    clear_mon();
    csb_low();
    spi_bits({8'd0, 8'h88, 16'h1234, 32'hDEADBEEF}, 56);
    csb_high();
    chk("wide write count", b_wq.size(), 1);
    if (b_wq.size() != 0) chk("wide write", b_wq[0], 48'h1234_DEADBEEF);
    $display("txn wide write: strobes=%0d", b_wq.size());

    clear_mon();
    csb_low();
    spi_bits({8'd0, 8'h48, 16'hABCD, 32'h0}, 56);
    csb_high();
    chk("wide read sdo", miso[31:0], 32'hCAFEF00D);
    chk("wide read addr", b_ack_addr, 16'hABCD);
    chk("wide read oe", b_oe_seen, 1'b1);
    chk("wide read underrun", b_unr_cnt, 0);
    $display("txn wide read: sdo=%h", miso[31:0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
